// File: rtl/cop0_ctrl_if.sv
// cop0_ctrl_if: MEM-stage <-> coprocessor-0 bus.
// master = issuing pipeline stage, slave = cop0_ctrl.
interface cop0_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_IRQ = 5
);
  logic [4:0]         reg_num;
  logic [2:0]         reg_sel;
  logic [DATA_W-1:0]  in_data;
  logic [DATA_W-1:0]  cur_pc;
  logic               reg_wr;
  logic               reg_rd;
  logic [2:0]         cop_op;
  logic [NUM_IRQ-1:0] irq;
  logic [DATA_W-1:0]  out_data;
  logic               exc_req;
  logic [DATA_W-1:0]  exc_target;
  logic               irq_pending;

  modport master (
    output reg_num, reg_sel, in_data, cur_pc, reg_wr, reg_rd, cop_op, irq,
    input  out_data, exc_req, exc_target, irq_pending
  );

  modport slave (
    input  reg_num, reg_sel, in_data, cur_pc, reg_wr, reg_rd, cop_op, irq,
    output out_data, exc_req, exc_target, irq_pending
  );
endinterface

// File: rtl/cop0_ctrl.sv
// cop0_ctrl: MIPS coprocessor-0 (Status, Cause, EPC, ErrorEPC, Count, Compare),
// cop_op micro-op execution, level-sensitive hardware interrupts and the
// one-cycle exception entry/return redirect into PC select.
// Optional macro COP0_TIMER_EN: free-running Count with Compare timer on IP7.
// Without it Count/Compare read 0, ignore writes, and IP7 is 0.
//
// Redirect FSM:
//   state    | meaning
//   ST_IDLE  | no redirect this cycle
//   ST_REDIR | exc_req=1, exc_target holds the captured vector/return PC
module cop0_ctrl #(
  parameter int               DATA_W  = 32,
  parameter int               NUM_IRQ = 5,
  parameter logic [DATA_W-1:0] EXC_VEC = 32'h8000_0180,
  parameter logic [DATA_W-1:0] BEV_VEC = 32'hBFC0_0380
) (
  input logic        clk,
  input logic        rst,
  cop0_ctrl_if.slave bus
);

  localparam logic [2:0] COP_OP_MV  = 3'd1;
  localparam logic [2:0] COP_OP_EN  = 3'd2;
  localparam logic [2:0] COP_OP_DIS = 3'd3;
  localparam logic [2:0] COP_OP_SYS = 3'd4;
  localparam logic [2:0] COP_OP_RET = 3'd5;
  localparam logic [2:0] COP_OP_BRK = 3'd6;

  localparam logic [DATA_W-1:0] STATUS_RST   = DATA_W'(32'h0040_0004);
  localparam logic [DATA_W-1:0] STATUS_WMASK = DATA_W'(32'h0040_FF17);

  typedef enum logic {ST_IDLE, ST_REDIR} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  target_q, target_d;

  logic [DATA_W-1:0]  status_q, status_d;
  logic [DATA_W-1:0]  epc_q, epc_d;
  logic [DATA_W-1:0]  errorepc_q, errorepc_d;
  logic [1:0]         ip_sw_q, ip_sw_d;
  logic [NUM_IRQ-1:0] ip_hw_q;
  logic [4:0]         exccode_q, exccode_d;
  logic               ip7;
  logic [DATA_W-1:0]  count_rd, compare_rd, cause;

  logic op_mv, op_en, op_dis, op_sys, op_brk, op_ret;
  logic wr_any, wr_status, wr_cause, wr_epc, wr_errorepc;
  logic irq_take, exc_entry, redir_evt;

  assign op_mv  = (bus.cop_op == COP_OP_MV);
  assign op_en  = (bus.cop_op == COP_OP_EN);
  assign op_dis = (bus.cop_op == COP_OP_DIS);
  assign op_sys = (bus.cop_op == COP_OP_SYS);
  assign op_brk = (bus.cop_op == COP_OP_BRK);
  assign op_ret = (bus.cop_op == COP_OP_RET);

  assign wr_any      = op_mv & bus.reg_wr & (bus.reg_sel == 3'd0);
  assign wr_status   = wr_any & (bus.reg_num == 5'd12);
  assign wr_cause    = wr_any & (bus.reg_num == 5'd13);
  assign wr_epc      = wr_any & (bus.reg_num == 5'd14);
  assign wr_errorepc = wr_any & (bus.reg_num == 5'd30);

  // Assemble Cause from its hardware- and software-owned fields
  always_comb begin
    cause = '0;
    cause[15] = ip7;
    for (int i = 0; i < NUM_IRQ; i++) begin
      cause[10+i] = ip_hw_q[i];
    end
    cause[9:8] = ip_sw_q;
    cause[6:2] = exccode_q;
  end

  assign bus.irq_pending = status_q[0] & ~status_q[1] & ~status_q[2]
                         & (|(cause[15:8] & status_q[15:8]));

  // SYS/BRK/RET own the cycle; a pending interrupt retries next cycle
  assign irq_take  = bus.irq_pending & ~(op_sys | op_brk | op_ret);
  assign exc_entry = op_sys | op_brk | irq_take;
  assign redir_evt = exc_entry | op_ret;

  // Read port: register value for mfc0, old Status for EN/DIS
  always_comb begin
    bus.out_data = '0;
    if (op_mv & bus.reg_rd & ~bus.reg_wr & (bus.reg_sel == 3'd0)) begin
      case (bus.reg_num)
        5'd9:    bus.out_data = count_rd;
        5'd11:   bus.out_data = compare_rd;
        5'd12:   bus.out_data = status_q;
        5'd13:   bus.out_data = cause;
        5'd14:   bus.out_data = epc_q;
        5'd30:   bus.out_data = errorepc_q;
        default: bus.out_data = '0;
      endcase
    end else if (op_en | op_dis) begin
      bus.out_data = status_q;
    end
  end

  // Next architectural state; hardware updates are applied after mtc0 so they win
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    errorepc_d = errorepc_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    if (wr_status)   status_d   = bus.in_data & STATUS_WMASK;
    if (wr_cause)    ip_sw_d    = bus.in_data[9:8];
    if (wr_epc)      epc_d      = bus.in_data;
    if (wr_errorepc) errorepc_d = bus.in_data;
    if (op_en)       status_d[0] = 1'b1;
    if (op_dis)      status_d[0] = 1'b0;
    if (exc_entry) begin
      epc_d       = bus.cur_pc;
      exccode_d   = op_sys ? 5'd8 : (op_brk ? 5'd9 : 5'd0);
      status_d[1] = 1'b1;
    end
    if (op_ret) begin
      if (status_q[2]) status_d[2] = 1'b0;
      else             status_d[1] = 1'b0;
    end
  end

  // Architectural register file
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      errorepc_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exccode_q  <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      errorepc_q <= errorepc_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= bus.irq;
      exccode_q  <= exccode_d;
    end
  end

`ifdef COP0_TIMER_EN
  logic              wr_count, wr_compare;
  logic [DATA_W-1:0] count_q, count_d, compare_q;
  logic              ip7_q, ip7_d;

  assign wr_count   = wr_any & (bus.reg_num == 5'd9);
  assign wr_compare = wr_any & (bus.reg_num == 5'd11);

  // Count advance and sticky compare match; a Compare write clears the match
  always_comb begin
    count_d = wr_count ? bus.in_data : count_q + DATA_W'(1);
    ip7_d   = ip7_q;
    if (count_d == compare_q) ip7_d = 1'b1;
    if (wr_compare)           ip7_d = 1'b0;
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ip7_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      ip7_q     <= ip7_d;
      if (wr_compare) compare_q <= bus.in_data;
    end
  end

  assign count_rd   = count_q;
  assign compare_rd = compare_q;
  assign ip7        = ip7_q;
`else
  assign count_rd   = '0;
  assign compare_rd = '0;
  assign ip7        = 1'b0;
`endif

  // Redirect target: vector on entry (BEV before update), EPC/ErrorEPC on return
  always_comb begin
    target_d = '0;
    if (exc_entry)   target_d = status_q[22] ? BEV_VEC : EXC_VEC;
    else if (op_ret) target_d = status_q[2] ? errorepc_q : epc_q;
  end

  // Redirect FSM state register; reset drops any pending pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (redir_evt) target_q <= target_d;
    end
  end

  // Redirect FSM next state: any entry or return redirects next cycle
  always_comb begin
    state_d = redir_evt ? ST_REDIR : ST_IDLE;
  end

  // Redirect FSM outputs
  always_comb begin
    bus.exc_req    = (state_q == ST_REDIR);
    bus.exc_target = bus.exc_req ? target_q : '0;
  end

endmodule

// File: tb/tb_cop0_ctrl.sv
// tb_cop0_ctrl: directed vector table, corner sequences and a randomized run
// against an architectural model of cop0_ctrl.
module tb_cop0_ctrl;

  localparam int OP_NONE = 0, OP_MV = 1, OP_EN = 2, OP_DIS = 3;
  localparam int OP_SYS = 4, OP_RET = 5, OP_BRK = 6;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  localparam logic [31:0] BEV_VEC = 32'hBFC0_0380;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  num;
    logic [2:0]  sel;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] pc;
    logic [4:0]  irq;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] out;
    logic        req;
    logic [31:0] tgt;
    logic        pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  cop0_ctrl_if #(.DATA_W(32), .NUM_IRQ(5)) bus ();

  cop0_ctrl #(.DATA_W(32), .NUM_IRQ(5), .EXC_VEC(EXC_VEC), .BEV_VEC(BEV_VEC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Architectural model: CP0 register words indexed by register number
  logic [31:0] m_reg [32];
  logic        m_rv;
  logic [31:0] m_rt;
  stim_t       cur_s;
  logic        cur_r;
  vec_t        tbl [$];

  function automatic stim_t mk(int op, int num, int wr, int rd,
                               logic [31:0] din, logic [31:0] pc, int irq);
    stim_t t;
    t.op = 3'(op); t.num = 5'(num); t.sel = 3'd0;
    t.wr = 1'(wr); t.rd = 1'(rd); t.din = din; t.pc = pc; t.irq = 5'(irq);
    return t;
  endfunction

  function automatic vec_t row(int op, int num, int wr, int rd, logic [31:0] din,
                               logic [31:0] pc, int irq, logic [31:0] out,
                               int req, logic [31:0] tgt, int pend);
    vec_t v;
    v.s = mk(op, num, wr, rd, din, pc, irq);
    v.out = out; v.req = 1'(req); v.tgt = tgt; v.pend = 1'(pend);
    return v;
  endfunction

  function automatic logic [31:0] wmask(int n);
    case (n)
      12:      return 32'h0040_FF17;
      13:      return 32'h0000_0300;
      14, 30:  return 32'hFFFF_FFFF;
`ifdef COP0_TIMER_EN
      9, 11:   return 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_pending();
    logic [31:0] st, ca;
    st = m_reg[12];
    ca = m_reg[13];
    return st[0] && !st[1] && !st[2] && ((ca[15:8] & st[15:8]) != 8'h0);
  endfunction

  function automatic logic [31:0] m_read(stim_t s);
    if (s.op == 3'(OP_MV) && s.rd && !s.wr) return (s.sel == 3'd0) ? m_reg[s.num] : 32'h0;
    if (s.op == 3'(OP_EN) || s.op == 3'(OP_DIS)) return m_reg[12];
    return 32'h0;
  endfunction

  task automatic m_edge(stim_t s, logic r);
    logic [31:0] st, mask, nxt_cnt;
    logic        pend, wr, entry, ret;
    logic [4:0]  code;
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_reg[12] = 32'h0040_0004;
      m_rv = 1'b0;
      m_rt = 32'h0;
      return;
    end
    st    = m_reg[12];
    pend  = m_pending();
    wr    = (s.op == 3'(OP_MV)) && s.wr && (s.sel == 3'd0);
    ret   = (s.op == 3'(OP_RET));
    entry = (s.op == 3'(OP_SYS)) || (s.op == 3'(OP_BRK)) || (pend && !ret);
    code  = (s.op == 3'(OP_SYS)) ? 5'd8 : ((s.op == 3'(OP_BRK)) ? 5'd9 : 5'd0);
    m_rv  = entry || ret;
    if (entry)    m_rt = st[22] ? BEV_VEC : EXC_VEC;
    else if (ret) m_rt = st[2] ? m_reg[30] : m_reg[14];
    nxt_cnt = 32'h0;
`ifdef COP0_TIMER_EN
    nxt_cnt = (wr && s.num == 5'd9) ? s.din : m_reg[9] + 32'd1;
    if (nxt_cnt == m_reg[11]) m_reg[13][15] = 1'b1;
`endif
    if (wr) begin
      mask = wmask(int'(s.num));
      m_reg[s.num] = (m_reg[s.num] & ~mask) | (s.din & mask);
    end
`ifdef COP0_TIMER_EN
    m_reg[9] = nxt_cnt;
    if (wr && s.num == 5'd11) m_reg[13][15] = 1'b0;
`endif
    if (s.op == 3'(OP_EN))  m_reg[12][0] = 1'b1;
    if (s.op == 3'(OP_DIS)) m_reg[12][0] = 1'b0;
    if (entry) begin
      m_reg[14]      = s.pc;
      m_reg[13][6:2] = code;
      m_reg[12][1]   = 1'b1;
    end
    if (ret) begin
      if (st[2]) m_reg[12][2] = 1'b0;
      else       m_reg[12][1] = 1'b0;
    end
    m_reg[13][14:10] = s.irq;
    if (nxt_cnt != 32'h0) m_rt = m_rt;
  endtask

  function automatic stim_t rand_stim();
    stim_t t;
    int nums [7] = '{9, 11, 12, 13, 14, 30, 0};
    t.op  = ($urandom_range(0, 9) < 5) ? 3'(OP_MV) : 3'($urandom_range(0, 7));
    t.num = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(nums[$urandom_range(0, 6)]);
    t.sel = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    t.wr  = 1'($urandom);
    t.rd  = 1'($urandom);
    t.din = $urandom;
    if (t.num == 5'd12 && $urandom_range(0, 3) != 0) t.din = t.din & ~32'h6;
    t.pc  = $urandom & ~32'h3;
    t.irq = 5'($urandom);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input stim_t s, input logic r);
    bus.cop_op  = s.op;
    bus.reg_num = s.num;
    bus.reg_sel = s.sel;
    bus.reg_wr  = s.wr;
    bus.reg_rd  = s.rd;
    bus.in_data = s.din;
    bus.cur_pc  = s.pc;
    bus.irq     = s.irq;
    rst         = r;
    cur_s       = s;
    cur_r       = r;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    m_edge(cur_s, cur_r);
    #1;
  endtask

  initial begin
    stim_t nop, s;
    logic  r;
    nop = mk(OP_NONE, 0, 0, 0, 0, 0, 0);

    //           op      num wr rd din            pc            irq out            req tgt           pend
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0040_0004, 0, 0,            0));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 1, 1, 32'h0,         0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_SYS,  0, 0, 0, 0,             32'h1000,     0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  14, 0, 1, 0,             0,            0, 32'h1000,      1, EXC_VEC,      0));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             0,            0, 32'h20,        0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h2,         0, 0,            0));
    tbl.push_back(row(OP_MV,  14, 1, 0, 32'h1004,      0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_RET,  0, 0, 0, 0,             0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0,         1, 32'h1004,     0));
    tbl.push_back(row(OP_MV,  30, 1, 0, 32'hBFC0_0000, 0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 1, 0, 32'h4,         0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_RET,  0, 0, 0, 0,             0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0,         1, 32'hBFC0_0000, 0));
    tbl.push_back(row(OP_MV,  12, 1, 0, 32'h401,       0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_NONE, 0, 0, 0, 0,             0,            1, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_NONE, 0, 0, 0, 0,             32'h2000,     1, 32'h0,         0, 0,            1));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             0,            1, 32'h400,       1, EXC_VEC,      0));
    tbl.push_back(row(OP_MV,  14, 0, 1, 0,             0,            0, 32'h2000,      0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 1, 0, 32'h401,       0,            1, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_SYS,  0, 0, 0, 0,             32'h3000,     1, 32'h0,         0, 0,            1));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             0,            1, 32'h420,       1, EXC_VEC,      0));
    tbl.push_back(row(OP_MV,  14, 0, 1, 0,             0,            1, 32'h3000,      0, 0,            0));
    tbl.push_back(row(OP_NONE, 0, 0, 0, 0,             0,            1, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 1, 0, 32'h0000_FF01, 0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_DIS,  0, 0, 0, 0,             0,            0, 32'h0000_FF01, 0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0000_FF00, 0, 0,            0));
    tbl.push_back(row(OP_EN,   0, 0, 0, 0,             0,            0, 32'h0000_FF00, 0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0000_FF01, 0, 0,            0));
    tbl.push_back(row(OP_MV,  13, 1, 0, 32'hFFFF_FFFF, 0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             32'h4000,     0, 32'h320,       0, 0,            1));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             0,            0, 32'h300,       1, EXC_VEC,      0));
    tbl.push_back(row(OP_MV,  15, 0, 1, 0,             0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0,         0, 0,            0));
    tbl[$].s.sel = 3'd1;
    tbl.push_back(row(OP_MV,  12, 1, 0, 32'h0040_0000, 0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_BRK,  0, 0, 0, 0,             32'h5000,     0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  13, 0, 1, 0,             0,            0, 32'h324,       1, BEV_VEC,      0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0040_0002, 0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 1, 0, 32'hFFFF_FFFF, 0,            0, 32'h0,         0, 0,            0));
    tbl.push_back(row(OP_MV,  12, 0, 1, 0,             0,            0, 32'h0040_FF17, 0, 0,            0));

    apply(nop, 1'b1); adv();
    apply(nop, 1'b1); adv();

    foreach (tbl[i]) begin
      apply(tbl[i].s, 1'b0);
      chk($sformatf("tbl%0d_out", i),  bus.out_data,    tbl[i].out);
      chk($sformatf("tbl%0d_req", i),  bus.exc_req,     tbl[i].req);
      chk($sformatf("tbl%0d_pend", i), bus.irq_pending, tbl[i].pend);
      if (tbl[i].req) chk($sformatf("tbl%0d_tgt", i), bus.exc_target, tbl[i].tgt);
      adv();
    end

    // reset during the event cycle and during the pulse cycle
    apply(mk(OP_SYS, 0, 0, 0, 0, 32'h100, 0), 1'b1); adv();
    apply(mk(OP_MV, 12, 0, 1, 0, 0, 0), 1'b0);
    chk("rst_kill_req", bus.exc_req, 1'b0);
    chk("rst_status", bus.out_data, 32'h0040_0004);
    adv();
    apply(mk(OP_SYS, 0, 0, 0, 0, 32'h104, 0), 1'b0); adv();
    apply(nop, 1'b1);
    chk("sys_req_bev", bus.exc_req, 1'b1);
    chk("sys_tgt_bev", bus.exc_target, BEV_VEC);
    adv();
    apply(nop, 1'b0);
    chk("rst_kill_req2", bus.exc_req, 1'b0);
    adv();

    // RET beats interrupt; interrupt taken the cycle after EXL clears
    apply(mk(OP_MV, 12, 1, 0, 32'h403, 0, 1), 1'b0); adv();
    apply(mk(OP_MV, 14, 1, 0, 32'h6000, 0, 1), 1'b0); adv();
    apply(mk(OP_RET, 0, 0, 0, 0, 0, 1), 1'b0);
    chk("ret_pend_blocked", bus.irq_pending, 1'b0);
    adv();
    apply(mk(OP_NONE, 0, 0, 0, 0, 32'h7000, 1), 1'b0);
    chk("ret_req", bus.exc_req, 1'b1);
    chk("ret_tgt", bus.exc_target, 32'h6000);
    chk("ret_then_pend", bus.irq_pending, 1'b1);
    adv();
    apply(mk(OP_MV, 14, 0, 1, 0, 0, 1), 1'b0);
    chk("irq_after_ret_req", bus.exc_req, 1'b1);
    chk("irq_after_ret_tgt", bus.exc_target, EXC_VEC);
    chk("irq_after_ret_epc", bus.out_data, 32'h7000);
    adv();

    // mtc0 EPC loses to a same-cycle interrupt entry
    apply(mk(OP_MV, 12, 1, 0, 32'h401, 0, 1), 1'b0); adv();
    apply(mk(OP_MV, 14, 1, 0, 32'hDEAD_0000, 32'h8000, 1), 1'b0);
    chk("hw_wins_pend", bus.irq_pending, 1'b1);
    adv();
    apply(mk(OP_MV, 14, 0, 1, 0, 0, 0), 1'b0);
    chk("hw_wins_epc", bus.out_data, 32'h8000);
    chk("hw_wins_req", bus.exc_req, 1'b1);
    adv();

`ifdef COP0_TIMER_EN
    apply(nop, 1'b1); adv();
    apply(mk(OP_MV, 11, 1, 0, 32'd5, 0, 0), 1'b0); adv();
    apply(mk(OP_MV, 9, 1, 0, 32'd0, 0, 0), 1'b0); adv();
    repeat (4) begin apply(nop, 1'b0); adv(); end
    apply(mk(OP_MV, 13, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_ip7_before", bus.out_data[15], 1'b0);
    adv();
    apply(mk(OP_MV, 13, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_ip7_set", bus.out_data[15], 1'b1);
    adv();
    apply(mk(OP_MV, 9, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_count", bus.out_data, 32'd6);
    adv();
    apply(mk(OP_MV, 13, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_ip7_sticky", bus.out_data[15], 1'b1);
    adv();
    apply(mk(OP_MV, 11, 1, 0, 32'd100, 0, 0), 1'b0); adv();
    apply(mk(OP_MV, 13, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_ip7_clear", bus.out_data[15], 1'b0);
    adv();
    apply(mk(OP_MV, 9, 1, 0, 32'hFFFF_FFFF, 0, 0), 1'b0); adv();
    apply(mk(OP_MV, 9, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_max", bus.out_data, 32'hFFFF_FFFF);
    adv();
    apply(mk(OP_MV, 9, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_wrap", bus.out_data, 32'h0);
    adv();
    apply(mk(OP_MV, 9, 1, 0, 32'd99, 0, 0), 1'b0); adv();
    apply(mk(OP_MV, 11, 1, 0, 32'd500, 0, 0), 1'b0); adv();
    apply(mk(OP_MV, 13, 0, 1, 0, 0, 0), 1'b0);
    chk("tmr_clear_wins", bus.out_data[15], 1'b0);
    adv();
`endif

    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
      r = ($urandom_range(0, 63) == 0);
      apply(s, r);
      chk("rnd_out", bus.out_data, m_read(s));
      chk("rnd_pend", bus.irq_pending, m_pending());
      chk("rnd_req", bus.exc_req, m_rv);
      if (m_rv) chk("rnd_tgt", bus.exc_target, m_rt);
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
